// File: rtl/bpsk_symbol_source.sv
// BPSK symbol source: bit FIFO, free-running carrier phase, symbol FSM.
// Optional differential encoding when BPSK_SYMBOL_SOURCE_DBPSK_EN is defined.
`ifndef ADC_BITS
`define ADC_BITS 12
`endif
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 20
`endif
`ifndef ADC_SAMPLING_FREQ
`define ADC_SAMPLING_FREQ 1000000
`endif
`ifndef CARRIER_FREQ
`define CARRIER_FREQ 50000
`endif

// 20-point cosine table, amplitude 2047, one combinational read per port.
module cosine_lut #(
  parameter int READ_PORTS = 1,
  parameter int IDX_W = 5,
  parameter int DATA_W = 16
) (
  input  logic [READ_PORTS*IDX_W-1:0]  index,
  output logic [READ_PORTS*DATA_W-1:0] value
);

  function automatic int cos20(input logic [IDX_W-1:0] k);
    case (int'(k))
      0:  return 2047;
      1:  return 1947;
      2:  return 1656;
      3:  return 1203;
      4:  return 633;
      5:  return 0;
      6:  return -633;
      7:  return -1203;
      8:  return -1656;
      9:  return -1947;
      10: return -2047;
      11: return -1947;
      12: return -1656;
      13: return -1203;
      14: return -633;
      15: return 0;
      16: return 633;
      17: return 1203;
      18: return 1656;
      19: return 1947;
      default: return 0;
    endcase
  endfunction

  // Table lookup for every read port.
  always_comb begin
    value = '0;
    for (int p = 0; p < READ_PORTS; p++)
      value[p*DATA_W +: DATA_W] =
        DATA_W'(cos20(index[p*IDX_W +: IDX_W]));
  end

endmodule

module bpsk_symbol_source #(
  parameter int SAMPLES_PER_SYMBOL = 20,
  parameter int FIFO_DEPTH = 8,
  parameter int PHASE_STEP = `CARRIER_SAMPLES_PER_PERIOD /
    (`ADC_SAMPLING_FREQ / `CARRIER_FREQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             bit_valid,
  input  logic                             bit_data,
  output logic                             bit_ready,
  output logic [`ADC_BITS-1:0]             sample_out,
  output logic                             sample_valid,
  output logic                             symbol_start,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int N   = `CARRIER_SAMPLES_PER_PERIOD;
  localparam int PW  = $clog2(N);
  localparam int PW1 = PW + 1;
  localparam int CW  = $clog2(SAMPLES_PER_SYMBOL);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = $clog2(FIFO_DEPTH+1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, state_next;
  logic [CW-1:0]          cnt, cnt_next;
  logic [FIFO_DEPTH-1:0]  mem;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic                   full, empty, push, pop, head;
  logic                   tx;
  logic [PW-1:0]          phase, phase_next, idx;
  logic [PW1-1:0]         ph_sum, ix_sum;
  logic [`ADC_BITS-1:0]   lut_val;

  assign full      = fifo_level == LW'(FIFO_DEPTH);
  assign empty     = fifo_level == '0;
  assign bit_ready = !full;
  assign push      = bit_valid && !full;
  assign head      = mem[rd_ptr];

  // Carrier phase step and symbol-offset index, both modulo N.
  always_comb begin
    ph_sum = {1'b0, phase} + PW1'(PHASE_STEP);
    phase_next = (ph_sum >= PW1'(N)) ?
      PW'(ph_sum - PW1'(N)) : PW'(ph_sum);
    ix_sum = {1'b0, phase} + (tx ? PW1'(N/2) : '0);
    idx = (ix_sum >= PW1'(N)) ?
      PW'(ix_sum - PW1'(N)) : PW'(ix_sum);
  end

  cosine_lut #(
    .READ_PORTS (1),
    .IDX_W      (PW),
    .DATA_W     (`ADC_BITS)
  ) u_lut (
    .index (idx),
    .value (lut_val)
  );

  // FSM next state, symbol counter and FIFO pop request.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && !empty) begin
          pop        = 1'b1;
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        if (!en) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CW'(SAMPLES_PER_SYMBOL-1)) begin
          cnt_next = '0;
          if (!empty) pop = 1'b1;
          else state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO storage; contents are don't-care once pointers reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bit_data;
  end

  // State, FIFO pointers, carrier phase, symbol phase and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      phase        <= '0;
      tx           <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      symbol_start <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      phase      <= phase_next;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
`ifdef BPSK_SYMBOL_SOURCE_DBPSK_EN
        tx <= tx ^ head;
`else
        tx <= head;
`endif
      end
      sample_out   <= (state == RUN) ? lut_val : '0;
      sample_valid <= state == RUN;
      symbol_start <= (state == RUN) && (cnt == '0);
    end
  end

endmodule

// File: tb/tb_bpsk_symbol_source.sv
// Bench for bpsk_symbol_source: vector table, directed corners,
// random traffic against a queue-based symbol model.
`ifndef ADC_BITS
`define ADC_BITS 12
`endif
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 20
`endif

module tb_bpsk_symbol_source;

  localparam int SPS   = 4;
  localparam int DEPTH = 4;
  localparam int N     = `CARRIER_SAMPLES_PER_PERIOD;
  localparam int STEP  = 1;
  localparam int B     = `ADC_BITS;
  localparam real AMP  = 2047.0;
  localparam real PI   = 3.14159265358979;

  logic         clk, rst_n, en, bit_valid, bit_data;
  logic         bit_ready, sample_valid, symbol_start;
  logic [B-1:0] sample_out;
  logic [2:0]   fifo_level;

  int total = 0;
  int bad = 0;

  bpsk_symbol_source #(
    .SAMPLES_PER_SYMBOL (SPS),
    .FIFO_DEPTH         (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst_n),
    .en           (en),
    .bit_valid    (bit_valid),
    .bit_data     (bit_data),
    .bit_ready    (bit_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .symbol_start (symbol_start),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  bit     q[$];
  bit     busy, cur, dph;
  int     left, ph, last_ph;
  bit     e_valid, e_start;
  logic [B-1:0] e_sample;

  function automatic logic [B-1:0] cosv(int k);
    real r;
    int v;
    r = AMP * $cos(2.0 * PI * k / N);
    if (r >= 0.0) v = $rtoi(r + 0.5);
    else v = -$rtoi(-r + 0.5);
    return v[B-1:0];
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    busy = 0; cur = 0; dph = 0; left = 0; ph = 0;
  endtask

  task automatic take();
    bit b;
    b = q.pop_front();
`ifdef BPSK_SYMBOL_SOURCE_DBPSK_EN
    dph = dph ^ b;
    cur = dph;
`else
    cur = b;
`endif
  endtask

  task automatic model_edge(bit e, bit v, bit d);
    int sz0;
    sz0 = q.size();
    e_valid = busy;
    e_start = busy && left == SPS;
    e_sample = busy ? cosv((ph + (cur ? N/2 : 0)) % N) : '0;
    last_ph = ph;
    if (busy) begin
      if (!e) busy = 0;
      else begin
        left--;
        if (left == 0) begin
          if (q.size() > 0) begin take(); left = SPS; end
          else busy = 0;
        end
      end
    end else if (e && q.size() > 0) begin
      take(); busy = 1; left = SPS;
    end
    if (v && sz0 < DEPTH) q.push_back(d);
    ph = (ph + STEP) % N;
  endtask

  task automatic step(bit e, bit v, bit d);
    @(negedge clk);
    en = e; bit_valid = v; bit_data = d;
    chk("ready_pre", int'(bit_ready), int'(q.size() < DEPTH));
    @(posedge clk);
    model_edge(e, v, d);
    #1;
    chk("valid", int'(sample_valid), int'(e_valid));
    chk("sample", int'(sample_out), int'(e_sample));
    chk("start", int'(symbol_start), int'(e_start));
    chk("level", int'(fifo_level), q.size());
    chk("ready", int'(bit_ready), int'(q.size() < DEPTH));
  endtask

  task automatic do_reset();
    en = 0; bit_valid = 0; bit_data = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
  endtask

  typedef struct {
    bit en, bv, bd;
    bit ev;
    int elev;
    bit erdy;
  } vec_t;

  vec_t tbl[8];
  int   nval, nsym;
  int   starts[$];
  bit   exp_ph[3];

  initial begin
    tbl[0] = '{1, 0, 0, 0, 0, 1};
    tbl[1] = '{1, 0, 0, 0, 0, 1};
    tbl[2] = '{0, 0, 0, 0, 0, 1};
    tbl[3] = '{0, 1, 1, 0, 1, 1};
    tbl[4] = '{0, 1, 0, 0, 2, 1};
    tbl[5] = '{0, 1, 1, 0, 3, 1};
    tbl[6] = '{0, 1, 1, 0, 4, 0};
    tbl[7] = '{0, 1, 0, 0, 4, 0};

    // idle with en high and nothing queued
    do_reset();
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_ready", int'(bit_ready), 1);
    chk("rst_level", int'(fifo_level), 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0);
      chk("idle_out", int'(sample_out), 0);
      chk("idle_valid", int'(sample_valid), 0);
    end

    // table: fill FIFO, fifth bit refused
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].en, tbl[i].bv, tbl[i].bd);
      chk("tbl_valid", int'(sample_valid), int'(tbl[i].ev));
      chk("tbl_level", int'(fifo_level), tbl[i].elev);
      chk("tbl_ready", int'(bit_ready), int'(tbl[i].erdy));
    end
    nval = 0;
    for (int i = 0; i < 24; i++) begin
      step(1, 0, 0);
      if (sample_valid) nval++;
    end
    chk("full_burst16", nval, 16);

    // two symbols: phase 1 then phase 0
    do_reset();
    step(0, 1, 1);
    step(0, 1, 0);
    nval = 0;
    starts.delete();
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0);
      if (sample_valid) begin
        nval++;
        if (symbol_start) starts.push_back(nval);
        chk("two_sym_cos", int'(sample_out),
          int'(cosv((last_ph + (nval <= 4 ? N/2 : 0)) % N)));
      end
    end
    chk("two_sym_n", nval, 8);
    chk("two_sym_starts", starts.size(), 2);
    if (starts.size() == 2) begin
      chk("start_a", starts[0], 1);
      chk("start_b", starts[1], 5);
    end

    // en dropped on second sample of a 3-bit burst
    do_reset();
    step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("drop_valid", int'(sample_valid), 0);
    chk("drop_level", int'(fifo_level), 2);
    nval = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0);
      if (sample_valid) nval++;
    end
    chk("resume_n", nval, 8);

    // transmitted phases for bits 1,1,0
`ifdef BPSK_SYMBOL_SOURCE_DBPSK_EN
    exp_ph = '{1, 0, 0};
`else
    exp_ph = '{1, 1, 0};
`endif
    do_reset();
    step(0, 1, 1);
    step(0, 1, 1);
    step(0, 1, 0);
    nsym = 0;
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 0);
      if (symbol_start && nsym < 3) begin
        chk("sym_phase", int'(sample_out),
          int'(cosv((last_ph + (exp_ph[nsym] ? N/2 : 0)) % N)));
        nsym++;
      end
    end
    chk("sym_count", nsym, 3);

    // async reset mid-symbol with three bits queued
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, i[0]);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("pre_rst_level", int'(fifo_level), 3);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", int'(sample_valid), 0);
    chk("arst_out", int'(sample_out), 0);
    chk("arst_start", int'(symbol_start), 0);
    chk("arst_level", int'(fifo_level), 0);
    chk("arst_ready", int'(bit_ready), 1);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1;
    for (int i = 0; i < 8; i++) step(1, 0, 0);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
        $urandom_range(0, 1) == 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bpsk_symbol_source.md
BPSK_SYMBOL_SOURCE -- requirements
Module: bpsk_symbol_source

Interface
REQ-001 SHALL have parameter SAMPLES_PER_SYMBOL, default 20, carrier samples per transmitted bit (≥2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, bit FIFO entries (power of two, ≥2).
REQ-003 SHALL have parameter PHASE_STEP, default `CARRIER_SAMPLES_PER_PERIOD/(`ADC_SAMPLING_FREQ/`CARRIER_FREQ), LUT index advance per clk.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  transmit enable.
REQ-007 bit_valid  input  1  bit_data offered.
REQ-008 bit_data  input  1  payload bit.
REQ-009 bit_ready  output  1  FIFO can accept; high = !full.
REQ-010 sample_out  output  `ADC_BITS  modulated sample, low `ADC_BITS of cosine_lut output.
REQ-011 sample_valid  output  1  sample_out carries a symbol sample.
REQ-012 symbol_start  output  1  one-cycle pulse aligned with first sample of each symbol.
REQ-013 fifo_level  output  $clog2(FIFO_DEPTH+1)  bits held in FIFO.

Function
REQ-014 SHALL buffer bits in a FIFO_DEPTH-entry FIFO; push when bit_valid && bit_ready.
REQ-015 bit_ready SHALL depend only on full; a push SHALL be refused when full even if a pop occurs that cycle.
REQ-016 No bypass: a bit pushed in cycle N SHALL be poppable no earlier than cycle N+1.
REQ-017 SHALL keep a $clog2(`CARRIER_SAMPLES_PER_PERIOD)-bit carrier phase advancing by PHASE_STEP every cycle in every state, wrapping modulo `CARRIER_SAMPLES_PER_PERIOD.
REQ-018 LUT index SHALL be carrier phase + symbol offset, modulo; offset = `CARRIER_SAMPLES_PER_PERIOD/2 for transmitted phase 1, 0 for phase 0.
REQ-019 SHALL instantiate cosine_lut with READ_PORTS=1; sample_out SHALL be registered, one cycle after index.
REQ-020 FSM states IDLE and RUN.
REQ-021 IDLE -> RUN when en && FIFO non-empty: pop bit, load offset, clear symbol counter.
REQ-022 RUN: symbol counter (width $clog2(SAMPLES_PER_SYMBOL)) increments each cycle; at SAMPLES_PER_SYMBOL-1 pop next bit and wrap to 0 if FIFO non-empty, else -> IDLE.
REQ-023 en low in RUN SHALL force IDLE next edge; current bit discarded, FIFO contents kept, counter cleared.
REQ-024 sample_valid SHALL be high exactly for samples produced from RUN indices (same one-cycle latency).
REQ-025 In IDLE, registered sample_out SHALL be 0.
REQ-026 symbol_start SHALL pulse with the registered sample of counter value 0.
REQ-027 Back-to-back bits SHALL produce contiguous symbols with no gap sample.

Reset
REQ-028 rst low SHALL asynchronously clear: FSM to IDLE, FIFO empty, fifo_level 0, bit_ready 1, carrier phase 0, counter 0, sample_out 0, sample_valid 0, symbol_start 0.
REQ-029 Reset mid-symbol SHALL discard the symbol and all FIFO contents.

Configuration
REQ-030 Macro BPSK_SYMBOL_SOURCE_DBPSK_EN defined: transmitted phase = previous transmitted phase XOR popped bit (bit 1 toggles 180°); phase state cleared only by rst, persists through IDLE.
REQ-031 Macro undefined: transmitted phase = popped bit directly; no differential state.

Verification (SAMPLES_PER_SYMBOL=4, FIFO_DEPTH=4, 20 samples/carrier-period at defaults)
REQ-032 Reset release, no bits, en=1, 20 cycles -> sample_valid=0, sample_out=0, bit_ready=1, fifo_level=0.
REQ-033 Push 1,0 then en=1 -> 8 contiguous valid samples; first 4 equal cosine at phase+half period, next 4 at phase+0; symbol_start high on samples 1 and 5; then IDLE.
REQ-034 Push 5 bits while en=0 -> fifo_level 4, bit_ready 0, 5th bit refused; en=1 -> exactly 16 valid samples.
REQ-035 en dropped on 2nd sample of a 3-bit burst -> sample_valid low next cycle, fifo_level=2; en re-raised -> 8 samples follow.
REQ-036 With BPSK_SYMBOL_SOURCE_DBPSK_EN, bits 1,1,0 -> transmitted phases 1,0,0; without, 1,1,0.
REQ-037 rst asserted mid-symbol with fifo_level 3 -> all outputs at reset values immediately, fifo_level 0.
